// File: rtl/card_dealer_if.sv
`default_nettype none
// ============================================================================
//  Module      : card_dealer_if
//  Description : Card interface between the card dealer (producer) and the
//                hand-tracking consumer. The master side drives the slot
//                outputs and status; the slave side drives the deal controls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface card_dealer_if;
   // Deal controls, driven by the consumer
   logic       deal;
   logic       new_hand;
   logic       cheat_en;
   logic [3:0] cheat_card;

   // Hand state, driven by the dealer
   logic [3:0] first_card;
   logic [3:0] second_card;
   logic [3:0] third_card;
   logic [3:0] fourth_card;
   logic [2:0] card_count;
   logic [5:0] hand_sum;
   logic       card_valid;
   logic       busy;
   logic       hand_done;

   modport master (
      input  deal,
      input  new_hand,
      input  cheat_en,
      input  cheat_card,
      output first_card,
      output second_card,
      output third_card,
      output fourth_card,
      output card_count,
      output hand_sum,
      output card_valid,
      output busy,
      output hand_done
   );

   modport slave (
      output deal,
      output new_hand,
      output cheat_en,
      output cheat_card,
      input  first_card,
      input  second_card,
      input  third_card,
      input  fourth_card,
      input  card_count,
      input  hand_sum,
      input  card_valid,
      input  busy,
      input  hand_done
   );
endinterface
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : card_dealer
//  Description : Deals pseudo-random cards (1..10, face cards count 10) into
//                four slots, one per deal request, keeping a running sum.
//                The hand completes at STAND_LIMIT or four cards and then
//                holds until new_hand. A free-running 16-bit LFSR supplies
//                candidates; out-of-range candidates are retried, with a
//                forced 10 after seven consecutive rejects.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_dealer #(
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int          STAND_LIMIT = 17
) (
   input  wire logic         clk,
   input  wire logic         rst,
   card_dealer_if.master     bus
);

   localparam logic [5:0] c_stand_limit = 6'(STAND_LIMIT);
   localparam logic [3:0] c_face_value  = 4'd10;
   localparam logic [2:0] c_max_rejects = 3'd7;
   localparam logic [2:0] c_full_count  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   logic [3:0]  w_raw;
   logic [3:0]  w_value;
   logic        w_cand_ok;
   logic        w_force;
   logic        w_take;
   logic [5:0]  w_sum_next;
   logic [2:0]  w_count_next;

   logic        w_write;
   logic        w_reject;

   logic [2:0]  r_rej_cnt;
   logic [3:0]  r_slot [0:3];
   logic [2:0]  r_card_count;
   logic [5:0]  r_hand_sum;
   logic        r_card_valid;

   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // Free-running Fibonacci LFSR; only reset stops it, new_hand does not
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end

   // Candidate selection, validity, face-card clamp and forced value
   always_comb begin
      w_raw     = bus.cheat_en ? bus.cheat_card : r_lfsr[3:0];
      w_cand_ok = (w_raw >= 4'd1) && (w_raw <= 4'd13);
      w_force   = (r_rej_cnt == c_max_rejects);
      if (w_force) begin
         w_value = c_face_value;
      end else if (w_raw > c_face_value) begin
         w_value = c_face_value;
      end else begin
         w_value = w_raw;
      end
      w_take       = w_cand_ok || w_force;
      w_sum_next   = r_hand_sum + {2'b00, w_value};
      w_count_next = r_card_count + 3'd1;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and slot-write decode; new_hand overrides any pending action
   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_reject     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.deal) begin
               w_state_next = S_DRAW;
            end
         end
         S_DRAW: begin
            if (w_take) begin
               w_write = 1'b1;
               if ((w_sum_next >= c_stand_limit) || (w_count_next == c_full_count)) begin
                  w_state_next = S_FULL;
               end else begin
                  w_state_next = S_IDLE;
               end
            end else begin
               w_reject = 1'b1;
            end
         end
         S_FULL: begin
            w_state_next = S_FULL;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (bus.new_hand) begin
         w_state_next = S_IDLE;
         w_write      = 1'b0;
         w_reject     = 1'b0;
      end
   end

   // Hand datapath: slots, count, sum, reject counter and the valid pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot[0]    <= 4'd0;
         r_slot[1]    <= 4'd0;
         r_slot[2]    <= 4'd0;
         r_slot[3]    <= 4'd0;
         r_card_count <= 3'd0;
         r_hand_sum   <= 6'd0;
         r_rej_cnt    <= 3'd0;
         r_card_valid <= 1'b0;
      end else if (bus.new_hand) begin
         r_slot[0]    <= 4'd0;
         r_slot[1]    <= 4'd0;
         r_slot[2]    <= 4'd0;
         r_slot[3]    <= 4'd0;
         r_card_count <= 3'd0;
         r_hand_sum   <= 6'd0;
         r_rej_cnt    <= 3'd0;
         r_card_valid <= 1'b0;
      end else begin
         r_card_valid <= w_write;
         if (w_write) begin
            // Only reachable with card_count < 4, so the low two bits index the slot
            r_slot[r_card_count[1:0]] <= w_value;
            r_card_count              <= w_count_next;
            r_hand_sum                <= w_sum_next;
            r_rej_cnt                 <= 3'd0;
         end else if (w_reject) begin
            r_rej_cnt <= r_rej_cnt + 3'd1;
         end
      end
   end

   assign bus.first_card  = r_slot[0];
   assign bus.second_card = r_slot[1];
   assign bus.third_card  = r_slot[2];
   assign bus.fourth_card = r_slot[3];
   assign bus.card_count  = r_card_count;
   assign bus.hand_sum    = r_hand_sum;
   assign bus.card_valid  = r_card_valid;
   assign bus.busy        = (r_state == S_DRAW);
   assign bus.hand_done   = (r_state == S_FULL);

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_dealer
//  Description : Self-checking bench for card_dealer. Directed deals push the
//                expected slot update into a scoreboard queue; a monitor pops
//                and compares on every card_valid pulse. Free-running hands
//                are checked against hand invariants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_dealer;

   typedef struct {
      int slot;
      int val;
      int cnt;
      int sum;
      int done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   card_dealer_if bus_if ();

   card_dealer #(
      .SEED        (16'hACE1),
      .STAND_LIMIT (17)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int   n_checks  = 0;
   int   n_fail    = 0;
   bit   rand_mode = 1'b0;
   exp_t sb_q[$];
   exp_t mon_e;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int slot_val(input int i);
      case (i)
         0:       return int'(bus_if.first_card);
         1:       return int'(bus_if.second_card);
         2:       return int'(bus_if.third_card);
         default: return int'(bus_if.fourth_card);
      endcase
   endfunction

   task automatic push(input int slot, input int val, input int cnt, input int sum, input int done);
      exp_t e;
      e.slot = slot; e.val = val; e.cnt = cnt; e.sum = sum; e.done = done;
      sb_q.push_back(e);
   endtask

   // Monitor: compare every card_valid pulse against the scoreboard or invariants
   always @(negedge clk) begin
      if (rst && bus_if.card_valid === 1'b1) begin
         if (rand_mode) begin
            int cnt, idx, v, total;
            cnt   = int'(bus_if.card_count);
            idx   = (cnt == 0) ? 0 : cnt - 1;
            v     = slot_val(idx);
            total = slot_val(0) + slot_val(1) + slot_val(2) + slot_val(3);
            check("rand_count_range", int'(cnt >= 1 && cnt <= 4), 1);
            check("rand_slot_range", int'(v >= 1 && v <= 10), 1);
            check("rand_sum_match", int'(bus_if.hand_sum), total);
            check("rand_done_rule", int'(bus_if.hand_done),
                  int'(total >= 17 || cnt == 4));
         end else if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_card_valid: card_valid=1, required 0");
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_slot_value", slot_val(mon_e.slot), mon_e.val);
            check("sb_card_count", int'(bus_if.card_count), mon_e.cnt);
            check("sb_hand_sum", int'(bus_if.hand_sum), mon_e.sum);
            check("sb_hand_done", int'(bus_if.hand_done), mon_e.done);
         end
      end
   end

   task automatic deal_and_wait(input string tag);
      bit got;
      @(posedge clk); #1 bus_if.deal = 1'b1;
      @(posedge clk); #1 bus_if.deal = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus_if.card_valid === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s_timeout: card_valid seen=0, required 1 within 20 cycles", tag);
      end
   endtask

   task automatic pulse_new_hand();
      @(posedge clk); #1 bus_if.new_hand = 1'b1;
      @(posedge clk); #1 bus_if.new_hand = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input int s0, input int s1, input int s2,
                                input int s3, input int cnt, input int sum, input int done,
                                input int bsy);
      check({tag, "_first"},  int'(bus_if.first_card),  s0);
      check({tag, "_second"}, int'(bus_if.second_card), s1);
      check({tag, "_third"},  int'(bus_if.third_card),  s2);
      check({tag, "_fourth"}, int'(bus_if.fourth_card), s3);
      check({tag, "_count"},  int'(bus_if.card_count),  cnt);
      check({tag, "_sum"},    int'(bus_if.hand_sum),    sum);
      check({tag, "_done"},   int'(bus_if.hand_done),   done);
      check({tag, "_busy"},   int'(bus_if.busy),        bsy);
   endtask

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int busy_cnt;
      bit clean;

      bus_if.deal       = 1'b0;
      bus_if.new_hand   = 1'b0;
      bus_if.cheat_en   = 1'b0;
      bus_if.cheat_card = 4'd0;
      rst               = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_outputs("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      // Idle after reset: nothing dealt, no card_valid
      repeat (10) @(posedge clk);
      #1 check_outputs("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);

      // Four fives: 5,10,15 then 20 completes the hand
      bus_if.cheat_en   = 1'b1;
      bus_if.cheat_card = 4'd5;
      push(0, 5, 1, 5, 0);  deal_and_wait("five_1");
      push(1, 5, 2, 10, 0); deal_and_wait("five_2");
      push(2, 5, 3, 15, 0); deal_and_wait("five_3");
      @(posedge clk); #1 check_outputs("three_fives", 5, 5, 5, 0, 3, 15, 0, 0);
      push(3, 5, 4, 20, 1); deal_and_wait("five_4");
      @(posedge clk); #1 check_outputs("four_fives", 5, 5, 5, 5, 4, 20, 1, 0);
      @(posedge clk); #1 bus_if.deal = 1'b1;
      @(posedge clk); #1 bus_if.deal = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_outputs("full_ignores_deal", 5, 5, 5, 5, 4, 20, 1, 0);
      pulse_new_hand();
      check_outputs("new_hand_clear", 0, 0, 0, 0, 0, 0, 0, 0);

      // Face card clamps to 10, then 7 stands exactly at the limit
      bus_if.cheat_card = 4'd12;
      push(0, 10, 1, 10, 0); deal_and_wait("face");
      bus_if.cheat_card = 4'd7;
      push(1, 7, 2, 17, 1);  deal_and_wait("seven");
      @(posedge clk); #1 check_outputs("stand_limit", 10, 7, 0, 0, 2, 17, 1, 0);
      pulse_new_hand();

      // Seven rejects then forced 10 on the eighth DRAW cycle
      bus_if.cheat_card = 4'd15;
      push(0, 10, 1, 10, 0);
      @(posedge clk); #1 bus_if.deal = 1'b1;
      @(posedge clk); #1 bus_if.deal = 1'b0;
      busy_cnt = 0;
      clean    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.busy !== 1'b1) break;
         busy_cnt++;
         if (bus_if.first_card !== 4'd0) clean = 1'b0;
      end
      check("reject_busy_cycles", busy_cnt, 8);
      check("reject_no_slot_write", int'(clean), 1);
      @(posedge clk); #1 check_outputs("forced_ten", 10, 0, 0, 0, 1, 10, 0, 0);
      pulse_new_hand();

      // Abort a draw with new_hand on the third DRAW cycle
      bus_if.cheat_card = 4'd0;
      @(posedge clk); #1 bus_if.deal = 1'b1;
      @(posedge clk); #1 bus_if.deal = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 check("abort_busy_before", int'(bus_if.busy), 1);
      bus_if.new_hand = 1'b1;
      @(posedge clk); #1 bus_if.new_hand = 1'b0;
      check_outputs("abort", 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) @(posedge clk);
      #1 check_outputs("abort_settled", 0, 0, 0, 0, 0, 0, 0, 0);

      // LFSR-driven hands checked by invariants
      bus_if.cheat_en = 1'b0;
      rand_mode       = 1'b1;
      for (int h = 0; h < 20; h++) begin
         pulse_new_hand();
         for (int d = 0; d < 6 && bus_if.hand_done !== 1'b1; d++) begin
            deal_and_wait("rand_deal");
         end
         check("rand_hand_completes", int'(bus_if.hand_done), 1);
      end
      pulse_new_hand();
      rand_mode = 1'b0;
      repeat (3) @(posedge clk);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Producer side of the card interface: generates pseudo-random card values and presents them on four registered slot outputs (first_card..fourth_card) for the hand-tracking state machine.
- Each deal request adds exactly one card to the next empty slot and keeps a running hand sum.
- A slot value of 0 means "no card yet", so the consumer sees cards appear one slot at a time.
- Once the hand is complete (sum >= STAND_LIMIT or four cards), further deals are ignored until new_hand.

Parameters:
SEED, 16'hACE1, LFSR reset value; must be nonzero.
STAND_LIMIT, 17, hand_sum threshold at which the hand is complete.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
deal  input  1  request one card; sampled only in IDLE
new_hand  input  1  clear hand; has priority over everything except rst
cheat_en  input  1  test override: use cheat_card instead of LFSR
cheat_card  input  4  override value when cheat_en=1
first_card  output  4  slot 0 card value, 0 = empty
second_card  output  4  slot 1 card value
third_card  output  4  slot 2 card value
fourth_card  output  4  slot 3 card value
card_count  output  3  cards dealt, 0..4
hand_sum  output  6  sum of slots, 0..40
card_valid  output  1  one-cycle pulse, the cycle after a slot is written
busy  output  1  high while in DRAW
hand_done  output  1  high in FULL

Behaviour:
- Reset (rst=0, async): all outputs 0, LFSR=SEED, state IDLE.
- LFSR: 16-bit Fibonacci, shifts left every cycle, free-running.
  - Feedback bit0 = b15^b13^b12^b10.
  - Never pauses, including during new_hand.
- Candidate each cycle:
  - r = cheat_en ? cheat_card : lfsr[3:0].
  - Valid iff 1 <= r <= 13; card value = (r > 10) ? 10 : r. Ace counts as 1.
  - Rejected candidates (0, 14, 15) cause a retry on the next cycle.
  - After 7 consecutive rejects, the 8th DRAW cycle forces value 10 (bounded latency).
- States:
  - IDLE: deal=1 -> DRAW; else stay.
  - DRAW: busy=1.
    - Valid candidate: write value to slot[card_count], card_count+1, hand_sum += value, reject counter cleared.
    - Next state FULL if new hand_sum >= STAND_LIMIT or new card_count == 4; else IDLE.
    - Invalid candidate: stay in DRAW, reject counter+1.
  - FULL: hand_done=1; deal ignored; stays until new_hand.
- Latency: deal high in IDLE at edge N -> DRAW from N+1.
  - Best case: slot written at edge N+2, card_valid high for the cycle after edge N+2.
  - Worst case: 8 DRAW cycles.
- card_valid: registered, exactly one cycle per written slot; never asserted for rejects.
- new_hand=1 at any edge, in any state:
  - Slots, card_count, hand_sum, reject counter cleared to 0.
  - Next state IDLE, card_valid=0 next cycle.
  - A draw in progress is aborted and no slot is written.
  - new_hand and deal in the same cycle: new_hand wins; deal is dropped.
- deal held high: one card per IDLE->DRAW->IDLE round trip, i.e. at most one card every 2 cycles. Not edge-detected.
- deal in DRAW: ignored (no queuing).
- Widths: hand_sum is 6-bit, max 40, no overflow possible. Slots written in order 0..3 only; no slot is ever rewritten without new_hand.
- rst asserted mid-DRAW: immediate clear to reset values, including the LFSR.

Test Plan:
- Reset then idle 10 cycles -> all slots 0, card_count=0, hand_sum=0, card_valid never high, hand_done=0.
- cheat_en=1, cheat_card=5; pulse deal 3 times, waiting for card_valid each time -> slots 5,5,5,0; card_count=3; hand_sum=15; fourth pulse -> fourth_card=5, hand_sum=20, hand_done=1; a further deal leaves all outputs unchanged.
- cheat_card=12 then 7, one deal each -> first_card=10, second_card=7, hand_sum=17, card_count=2, hand_done=1 (stand at limit).
- cheat_card=15 held, pulse deal -> busy high 8 cycles, then first_card=10 and one card_valid pulse; no slot written during the 7 rejects.
- cheat_card=0 held, deal -> enters DRAW; assert new_hand on the 3rd DRAW cycle -> state IDLE, busy=0, all slots 0, no card_valid pulse.
- cheat_en=0, 20 hands of deal-until-hand_done -> every slot value in 1..10, hand_sum equals the sum of the slots, card_count <= 4, hand_done iff sum>=17 or count==4.
